kmeans_point_loader: RTL
========================

Name: kmeans_point_loader

Overview:
- Writer side of the k-means point memory: accepts a valid/ready stream of (x, y) points and writes each one as a 31-bit word {x[13:0], y[13:0], cluster[2:0]} into the point RAM.
- Writes into consecutive addresses starting at 0. The cluster field is set to an "unassigned" code.
- Sits in front of the assign/sum stages. Its done output is the trigger for the first cluster-assignment pass.
- Drives the same memory port signals the readers use: enable, adr, din, ren, wen.

Parameters:
- DEPTH, 1001, number of point-memory words; valid addresses are 0..DEPTH-1.
- ADDR_W, 10, memory address width.
- COORD_W, 14, width of each coordinate.
- CLUSTER_W, 3, width of the cluster field.
- INIT_CLUSTER, 3'd7, cluster code written with every point. Outside 0..4, so the summing stage ignores unassigned points.
- MAX_COORD, 14'd10000, coordinate ceiling; used only when the optional clamp feature is compiled in.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load session.
- abort  in  1  one-cycle pulse; cancels the session in progress.
- num_points  in  ADDR_W  number of points to load; sampled on start.
- in_valid  in  1  input point valid.
- in_ready  out  1  loader can accept a point.
- in_x  in  COORD_W  point x.
- in_y  in  COORD_W  point y.
- in_last  in  1  marks the final point; qualified by the accept.
- mem_enable  out  1  memory enable.
- mem_adr  out  ADDR_W  write address.
- mem_din  out  2*COORD_W+CLUSTER_W  write data.
- mem_ren  out  1  memory read enable; tied 0.
- mem_wen  out  1  memory write strobe.
- busy  out  1  session in progress.
- done  out  1  load complete.
- count  out  ADDR_W  number of points written.
- err_size  out  1  num_points exceeded DEPTH and was truncated.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0, mem_enable=0, mem_wen=0, mem_ren=0, mem_adr=0, mem_din=0, busy=0, done=0, count=0, err_size=0. Every output is registered except in_ready.
- States: IDLE, LOAD, FIN.
- IDLE:
  - start=1 latches target = min(num_points, DEPTH).
  - err_size is set to 1 if num_points > DEPTH, otherwise cleared.
  - done and count are cleared.
  - If target=0, go to FIN; otherwise go to LOAD with busy=1.
- LOAD, accept:
  - in_ready=1 combinationally whenever state==LOAD.
  - Accept = in_valid & in_ready.
  - On the clock edge of an accept, the next-cycle outputs are: mem_enable=1, mem_wen=1, mem_adr=count, mem_din={x, y, INIT_CLUSTER}.
  - count increments on the same edge.
  - Write latency is exactly 1 cycle after accept. mem_wen is a single-cycle strobe per point; back-to-back accepts give back-to-back writes.
- LOAD, cycles with no accept: mem_wen=0, and mem_adr/mem_din hold their last values.
- LOAD to FIN: taken on the accept that makes count equal target, or on any accept with in_last=1, whichever comes first.
  - in_ready drops in FIN, so no accept can happen after the final point.
  - The final write is still issued in the first FIN cycle.
- FIN:
  - One cycle after entry, done=1 and busy=0.
  - done holds until the next start or reset. mem_enable returns to 0.
- start while busy is ignored. start while in FIN or done behaves as from IDLE and begins a new session.
- abort:
  - Allowed in LOAD or FIN; returns to IDLE with done=0 and busy=0.
  - A write already scheduled for the next cycle still completes.
  - count keeps the number of points actually written.
- abort and start in the same cycle: abort wins.
- in_last with count+1 < target: the session ends early with a normal done; count reports the actual number of points.
- Address never exceeds DEPTH-1: target is clamped, and count cannot pass target.
- mem_ren is constant 0, so the memory never sees ren=wen=1.

Optional Feature:
- Macro: KMEANS_LOADER_CLAMP_EN.
- Defined: each accepted coordinate greater than MAX_COORD is written as MAX_COORD. A sticky output clamp_seen (1 bit, reset 0, cleared on start) goes to 1 on any clamp.
- Undefined: coordinates are written unmodified, and the clamp_seen port does not exist.

Test Plan:
- Reset, then start with num_points=3; stream (1,2), (3,4), (5,6) on consecutive cycles.
  - Required: mem_wen high for 3 consecutive cycles at adr 0, 1, 2.
  - Required: mem_din = {14'd1,14'd2,3'd7} and so on.
  - Required: done=1 one cycle after the last write; count=3.
- start num_points=4, with in_valid toggling 1,0,1,0...
  - Required: writes occur only 1 cycle after each accept; adr 0..3 with no gaps in addressing; done with count=4.
- start num_points=10; in_last asserted on the 2nd point.
  - Required: exactly 2 writes; in_ready=0 afterwards; done=1, count=2.
- start num_points=1023.
  - Required: err_size=1; exactly 1001 writes at adr 0..1000; done with count=1001.
- start num_points=5; abort after 2 accepts.
  - Required: the 2nd write still completes; state IDLE; done=0, count=2.
- Reset mid-load: rst_n low.
  - Required: mem_wen, busy and done drop immediately (asynchronously).
- With clamp enabled: point (12000, 50).
  - Required: mem_din={14'd10000, 14'd50, 3'd7}; clamp_seen=1.

Source files
------------

// File: rtl/kmeans_point_loader.sv
// kmeans_point_loader: writer side of the k-means point memory.
// Accepts a valid/ready stream of (x, y) points and writes each one as
// {x, y, INIT_CLUSTER} to consecutive addresses starting at 0. The done
// output triggers the first cluster-assignment pass.
// Optional build macro KMEANS_LOADER_CLAMP_EN: saturates coordinates above
// MAX_COORD and adds the sticky clamp_seen output.
module kmeans_point_loader #(
  parameter int DEPTH     = 1001,
  parameter int ADDR_W    = 10,
  parameter int COORD_W   = 14,
  parameter int CLUSTER_W = 3,
  parameter logic [CLUSTER_W-1:0] INIT_CLUSTER = 3'd7
`ifdef KMEANS_LOADER_CLAMP_EN
  ,
  parameter logic [COORD_W-1:0] MAX_COORD = 14'd10000
`endif
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [ADDR_W-1:0]                 num_points,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [COORD_W-1:0]                in_x,
  input  logic [COORD_W-1:0]                in_y,
  input  logic                              in_last,
  output logic                              mem_enable,
  output logic [ADDR_W-1:0]                 mem_adr,
  output logic [2*COORD_W+CLUSTER_W-1:0]    mem_din,
  output logic                              mem_ren,
  output logic                              mem_wen,
  output logic                              busy,
  output logic                              done,
  output logic [ADDR_W-1:0]                 count,
  output logic                              err_size
`ifdef KMEANS_LOADER_CLAMP_EN
  ,
  output logic                              clamp_seen
`endif
);

  localparam int DATA_W = 2*COORD_W + CLUSTER_W;
  // DEPTH widened by one bit so an oversize num_points compares cleanly.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [ADDR_W:0]     target_r;
  logic [ADDR_W-1:0]   count_r;
  logic [ADDR_W-1:0]   mem_adr_r;
  logic [DATA_W-1:0]   mem_din_r;
  logic                mem_wen_r;
  logic                mem_enable_r;
  logic                busy_r;
  logic                done_r;
  logic                err_size_r;

  logic                accept_s;
  logic                start_ok_s;
  logic                abort_ok_s;
  logic                final_s;
  logic                oversize_s;
  logic [ADDR_W:0]     num_ext_s;
  logic [ADDR_W:0]     target_s;
  logic [ADDR_W:0]     count_inc_s;
  logic [COORD_W-1:0]  x_s;
  logic [COORD_W-1:0]  y_s;

`ifdef KMEANS_LOADER_CLAMP_EN
  logic                clamp_seen_r;
  logic                clamp_hit_s;

  // Saturate one coordinate at the ceiling.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v);
    logic [COORD_W-1:0] r;
    if (v > MAX_COORD) begin
      r = MAX_COORD;
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  // Points are only accepted while a load session is actively filling memory.
  assign in_ready = (state_r == ST_LOAD);

  // Handshake qualification, session target and end-of-load detection.
  always_comb begin
    num_ext_s   = {1'b0, num_points};
    oversize_s  = (num_ext_s > DEPTH_C);
    if (oversize_s) begin
      target_s = DEPTH_C;
    end else begin
      target_s = num_ext_s;
    end
    accept_s    = in_valid & in_ready;
    // Abort takes priority over start; a running load ignores start.
    start_ok_s  = start & ~abort & (state_r != ST_LOAD);
    abort_ok_s  = abort & (state_r != ST_IDLE);
    count_inc_s = {1'b0, count_r} + {{ADDR_W{1'b0}}, 1'b1};
    final_s     = accept_s & (in_last | (count_inc_s == target_r));
`ifdef KMEANS_LOADER_CLAMP_EN
    x_s         = clamp_coord(in_x);
    y_s         = clamp_coord(in_y);
    clamp_hit_s = accept_s & ((in_x > MAX_COORD) | (in_y > MAX_COORD));
`else
    x_s         = in_x;
    y_s         = in_y;
`endif
  end

  // Next-state logic for the IDLE / LOAD / FIN session sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if (target_s == {(ADDR_W+1){1'b0}}) begin
            state_nx_s = ST_FIN;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_ok_s) begin
          state_nx_s = ST_IDLE;
        end else if (final_s) begin
          state_nx_s = ST_FIN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_FIN: begin
        if (abort_ok_s) begin
          state_nx_s = ST_IDLE;
        end else if (start_ok_s) begin
          if (target_s == {(ADDR_W+1){1'b0}}) begin
            state_nx_s = ST_FIN;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_FIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Session state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Memory write port, point counter and session status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_r     <= {(ADDR_W+1){1'b0}};
      count_r      <= {ADDR_W{1'b0}};
      mem_adr_r    <= {ADDR_W{1'b0}};
      mem_din_r    <= {DATA_W{1'b0}};
      mem_wen_r    <= 1'b0;
      mem_enable_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_size_r   <= 1'b0;
`ifdef KMEANS_LOADER_CLAMP_EN
      clamp_seen_r <= 1'b0;
`endif
    end else begin
      // A write launched by an accept always completes, even across abort.
      if (accept_s) begin
        mem_wen_r    <= 1'b1;
        mem_enable_r <= 1'b1;
        mem_adr_r    <= count_r;
        mem_din_r    <= {x_s, y_s, INIT_CLUSTER};
      end else begin
        mem_wen_r    <= 1'b0;
        mem_enable_r <= 1'b0;
      end

      // Start and accept never coincide: start is ignored while loading.
      if (start_ok_s) begin
        count_r <= {ADDR_W{1'b0}};
      end else if (accept_s) begin
        count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end

      if (abort_ok_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else if (start_ok_s) begin
        target_r   <= target_s;
        err_size_r <= oversize_s;
        done_r     <= 1'b0;
        busy_r     <= (target_s != {(ADDR_W+1){1'b0}});
      end else if (state_r == ST_FIN) begin
        // The final write occupies the first FIN cycle; done follows it.
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
        done_r <= done_r;
      end

`ifdef KMEANS_LOADER_CLAMP_EN
      if (start_ok_s) begin
        clamp_seen_r <= 1'b0;
      end else if (clamp_hit_s) begin
        clamp_seen_r <= 1'b1;
      end else begin
        clamp_seen_r <= clamp_seen_r;
      end
`endif
    end
  end

  assign mem_enable = mem_enable_r;
  assign mem_adr    = mem_adr_r;
  assign mem_din    = mem_din_r;
  assign mem_wen    = mem_wen_r;
  // Read port is never used by the loader, so ren and wen cannot collide.
  assign mem_ren    = 1'b0;
  assign busy       = busy_r;
  assign done       = done_r;
  assign count      = count_r;
  assign err_size   = err_size_r;
`ifdef KMEANS_LOADER_CLAMP_EN
  assign clamp_seen = clamp_seen_r;
`endif

endmodule
